// File: rtl/rggen_rtl_pkg.sv
// Shared access/status encodings used by rggen bus-side blocks.
package rggen_rtl_pkg;

  typedef enum logic [1:0] {
    RGGEN_POSTED_WRITE = 2'b01,
    RGGEN_READ         = 2'b10,
    RGGEN_WRITE        = 2'b11
  } rggen_access;

  typedef enum logic [1:0] {
    RGGEN_OKAY         = 2'b00,
    RGGEN_EXOKAY       = 2'b01,
    RGGEN_SLAVE_ERROR  = 2'b10,
    RGGEN_DECODE_ERROR = 2'b11
  } rggen_status;

endpackage

// File: rtl/rggen_bus_if.sv
// Host-side register bus: valid/ready request with status and read data return.
interface rggen_bus_if
  import rggen_rtl_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH     = 32
);
  logic                     valid;
  rggen_access              access;
  logic [ADDRESS_WIDTH-1:0] address;
  logic [BUS_WIDTH-1:0]     write_data;
  logic [BUS_WIDTH/8-1:0]   strobe;
  logic                     ready;
  rggen_status              status;
  logic [BUS_WIDTH-1:0]     read_data;

  modport master (
    output valid, access, address, write_data, strobe,
    input  ready, status, read_data
  );

  modport slave (
    input  valid, access, address, write_data, strobe,
    output ready, status, read_data
  );
endinterface

// File: rtl/rggen_wishbone_if.sv
// Wishbone B4 master/slave signal bundle.
interface rggen_wishbone_if #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH     = 32
);
  logic                     cyc;
  logic                     stb;
  logic                     stall;
  logic [ADDRESS_WIDTH-1:0] adr;
  logic                     we;
  logic [BUS_WIDTH-1:0]     dat_w;
  logic [BUS_WIDTH/8-1:0]   sel;
  logic                     ack;
  logic                     err;
  logic                     rty;
  logic [BUS_WIDTH-1:0]     dat_r;

  modport master (
    output cyc, stb, adr, we, dat_w, sel,
    input  stall, ack, err, rty, dat_r
  );

  modport slave (
    input  cyc, stb, adr, we, dat_w, sel,
    output stall, ack, err, rty, dat_r
  );
endinterface

// File: rtl/rggen_wishbone_bridge.sv
// Turns one rggen bus request into one Wishbone B4 cycle, with bounded rty retry
// and an optional termination timeout.
module rggen_wishbone_bridge
  import rggen_rtl_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 8,
  parameter int BUS_WIDTH      = 32,
  parameter bit USE_STALL      = 1'b1,
  parameter int RETRY_LIMIT    = 2,
  parameter int TIMEOUT_CYCLES = 0
) (
  input logic              i_clk,
  input logic              i_rst,
  rggen_bus_if.slave       bus_if,
  rggen_wishbone_if.master wishbone_if
);

  localparam int TimerWidth = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int RetryWidth = (RETRY_LIMIT > 0) ? $clog2(RETRY_LIMIT + 1) : 1;
  localparam logic [TimerWidth-1:0] TimerLimit = TimerWidth'(TIMEOUT_CYCLES);
  localparam logic [RetryWidth-1:0] RetryMax   = RetryWidth'(RETRY_LIMIT);

  typedef enum logic [1:0] {StIdle, StRequest, StWait, StRespond} state_e;

  state_e                   state_q, state_d;
  logic                     cyc_q, cyc_d;
  logic                     stb_q, stb_d;
  logic                     we_q, we_d;
  logic [ADDRESS_WIDTH-1:0] adr_q, adr_d;
  logic [BUS_WIDTH-1:0]     dat_w_q, dat_w_d;
  logic [BUS_WIDTH/8-1:0]   sel_q, sel_d;
  logic                     ready_q, ready_d;
  rggen_status              status_q, status_d;
  logic [BUS_WIDTH-1:0]     read_data_q, read_data_d;
  logic [RetryWidth-1:0]    retry_q, retry_d;
  logic [TimerWidth-1:0]    timer_q, timer_d;
  logic                     relaunch_q, relaunch_d;

  logic                     terminate, check_term, tick, respond, resp_err;
  logic [TimerWidth-1:0]    timer_inc;

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_w_d     = dat_w_q;
    sel_d       = sel_q;
    ready_d     = 1'b0;
    status_d    = status_q;
    read_data_d = read_data_q;
    retry_d     = retry_q;
    timer_d     = timer_q;
    relaunch_d  = relaunch_q;
    check_term  = 1'b0;
    tick        = 1'b0;
    respond     = 1'b0;
    resp_err    = 1'b0;
    terminate   = wishbone_if.err | wishbone_if.rty | wishbone_if.ack;
    timer_inc   = timer_q + 1'b1;

    unique case (state_q)
      StIdle: begin
        if (bus_if.valid) begin
          we_d    = (bus_if.access == RGGEN_WRITE);
          adr_d   = bus_if.address;
          dat_w_d = bus_if.write_data;
          sel_d   = (bus_if.access == RGGEN_WRITE) ? bus_if.strobe : '1;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          retry_d = '0;
          timer_d = '0;
          state_d = StRequest;
        end
      end
      StRequest: begin
        // relaunch_q marks the one-cycle cyc gap after a retried rty
        if (relaunch_q) begin
          cyc_d      = 1'b1;
          stb_d      = 1'b1;
          relaunch_d = 1'b0;
        end else if (USE_STALL) begin
          if (!wishbone_if.stall) begin
            stb_d      = 1'b0;
            timer_d    = '0;
            state_d    = StWait;
            check_term = 1'b1;
          end
        end else begin
          check_term = 1'b1;
          tick       = 1'b1;
        end
      end
      StWait: begin
        check_term = 1'b1;
        tick       = 1'b1;
      end
      StRespond: begin
        state_d = StIdle;
        retry_d = '0;
        timer_d = '0;
      end
      default: state_d = StIdle;
    endcase

    if (check_term && terminate) begin
      if (wishbone_if.err) begin
        respond  = 1'b1;
        resp_err = 1'b1;
      end else if (wishbone_if.rty && (retry_q < RetryMax)) begin
        cyc_d      = 1'b0;
        stb_d      = 1'b0;
        relaunch_d = 1'b1;
        retry_d    = retry_q + 1'b1;
        timer_d    = '0;
        state_d    = StRequest;
      end else if (wishbone_if.rty) begin
        respond  = 1'b1;
        resp_err = 1'b1;
      end else begin
        respond = 1'b1;
      end
    end else if (tick && (TIMEOUT_CYCLES > 0)) begin
      if (timer_inc == TimerLimit) begin
        respond  = 1'b1;
        resp_err = 1'b1;
      end else begin
        timer_d = timer_inc;
      end
    end

    if (respond) begin
      cyc_d       = 1'b0;
      stb_d       = 1'b0;
      ready_d     = 1'b1;
      state_d     = StRespond;
      status_d    = resp_err ? RGGEN_SLAVE_ERROR : RGGEN_OKAY;
      read_data_d = (resp_err || we_q) ? '0 : wishbone_if.dat_r;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= StIdle;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_w_q     <= '0;
      sel_q       <= '0;
      ready_q     <= 1'b0;
      status_q    <= RGGEN_OKAY;
      read_data_q <= '0;
      retry_q     <= '0;
      timer_q     <= '0;
      relaunch_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_w_q     <= dat_w_d;
      sel_q       <= sel_d;
      ready_q     <= ready_d;
      status_q    <= status_d;
      read_data_q <= read_data_d;
      retry_q     <= retry_d;
      timer_q     <= timer_d;
      relaunch_q  <= relaunch_d;
    end
  end

  assign wishbone_if.cyc   = cyc_q;
  assign wishbone_if.stb   = stb_q;
  assign wishbone_if.we    = we_q;
  assign wishbone_if.adr   = adr_q;
  assign wishbone_if.dat_w = dat_w_q;
  assign wishbone_if.sel   = sel_q;
  assign bus_if.ready      = ready_q;
  assign bus_if.status     = status_q;
  assign bus_if.read_data  = read_data_q;

endmodule

// File: tb/tb_rggen_wishbone_bridge.sv
// Bench for rggen_wishbone_bridge: pipelined and classic instances share one host
// driver and one scripted Wishbone slave; a transaction-level model predicts outcomes.
module tb_rggen_wishbone_bridge;
  import rggen_rtl_pkg::*;

  localparam int KAck    = 0;
  localparam int KErr    = 1;
  localparam int KRty    = 2;
  localparam int KSilent = 3;
  localparam int KErrAck = 4;

  logic clk = 1'b0;
  logic i_rst = 1'b1;
  always #5 clk = ~clk;

  bit          classic = 1'b0;
  logic        valid = 1'b0;
  rggen_access acc = RGGEN_READ;
  logic [7:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  strb = '0;
  logic        stall, ack, err, rty;
  logic [31:0] dat_r;

  rggen_bus_if #(.ADDRESS_WIDTH(8), .BUS_WIDTH(32)) bus_p ();
  rggen_bus_if #(.ADDRESS_WIDTH(8), .BUS_WIDTH(32)) bus_c ();
  rggen_wishbone_if #(.ADDRESS_WIDTH(8), .BUS_WIDTH(32)) wb_p ();
  rggen_wishbone_if #(.ADDRESS_WIDTH(8), .BUS_WIDTH(32)) wb_c ();

  rggen_wishbone_bridge #(
    .ADDRESS_WIDTH(8), .BUS_WIDTH(32), .USE_STALL(1'b1), .RETRY_LIMIT(2), .TIMEOUT_CYCLES(8)
  ) dut_p (
    .i_clk(clk), .i_rst(i_rst), .bus_if(bus_p), .wishbone_if(wb_p)
  );

  rggen_wishbone_bridge #(
    .ADDRESS_WIDTH(8), .BUS_WIDTH(32), .USE_STALL(1'b0), .RETRY_LIMIT(2), .TIMEOUT_CYCLES(8)
  ) dut_c (
    .i_clk(clk), .i_rst(i_rst), .bus_if(bus_c), .wishbone_if(wb_c)
  );

  assign bus_p.valid = valid & !classic;
  assign bus_c.valid = valid & classic;
  assign bus_p.access = acc;
  assign bus_c.access = acc;
  assign bus_p.address = addr;
  assign bus_c.address = addr;
  assign bus_p.write_data = wdata;
  assign bus_c.write_data = wdata;
  assign bus_p.strobe = strb;
  assign bus_c.strobe = strb;
  assign wb_p.stall = stall;
  assign wb_c.stall = stall;
  assign wb_p.ack = ack;
  assign wb_c.ack = ack;
  assign wb_p.err = err;
  assign wb_c.err = err;
  assign wb_p.rty = rty;
  assign wb_c.rty = rty;
  assign wb_p.dat_r = dat_r;
  assign wb_c.dat_r = dat_r;

  logic        rdy, cyc, stb, we;
  rggen_status sts;
  logic [31:0] rdat, dat_w;
  logic [7:0]  adr;
  logic [3:0]  sel;
  assign rdy   = classic ? bus_c.ready : bus_p.ready;
  assign sts   = classic ? bus_c.status : bus_p.status;
  assign rdat  = classic ? bus_c.read_data : bus_p.read_data;
  assign cyc   = classic ? wb_c.cyc : wb_p.cyc;
  assign stb   = classic ? wb_c.stb : wb_p.stb;
  assign we    = classic ? wb_c.we : wb_p.we;
  assign adr   = classic ? wb_c.adr : wb_p.adr;
  assign dat_w = classic ? wb_c.dat_w : wb_p.dat_w;
  assign sel   = classic ? wb_c.sel : wb_p.sel;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slave script, one entry per bus attempt: stall cycles, termination delay, kind
  int          scr_s[3];
  int          scr_d[3];
  int          scr_k[3];
  logic [31:0] scr_rdata;
  int          att;
  int          attr_bad;
  int          stb_cnt[3];

  task automatic set_att(input int k, input int s, input int d, input int kind);
    scr_s[k] = s;
    scr_d[k] = d;
    scr_k[k] = kind;
  endtask

  initial begin
    int t;
    int k;
    int term_t;
    bit active;
    stall = 1'b0; ack = 1'b0; err = 1'b0; rty = 1'b0; dat_r = '0;
    active = 1'b0;
    t = 0;
    forever begin
      @(negedge clk);
      ack = 1'b0; err = 1'b0; rty = 1'b0; stall = 1'b0; dat_r = $urandom;
      if (cyc) begin
        k = (att < 3) ? att : 2;
        if (!active) begin
          active = 1'b1;
          t = 0;
          if (we !== (acc == RGGEN_WRITE) || adr !== addr ||
              sel !== ((acc == RGGEN_WRITE) ? strb : 4'hF) ||
              ((acc == RGGEN_WRITE) && dat_w !== wdata)) attr_bad++;
        end else begin
          t++;
        end
        if (stb) stb_cnt[k]++;
        stall  = classic ? 1'b1 : (t < scr_s[k]);
        term_t = classic ? scr_d[k] : scr_s[k] + scr_d[k];
        if (t == term_t) begin
          case (scr_k[k])
            KAck:    begin ack = 1'b1; dat_r = scr_rdata; end
            KErr:    err = 1'b1;
            KRty:    rty = 1'b1;
            KErrAck: begin ack = 1'b1; err = 1'b1; dat_r = scr_rdata; end
            default: ;
          endcase
        end
      end else if (active) begin
        active = 1'b0;
        att++;
      end
    end
  end

  // Transaction-level prediction: ready cycle counted from the valid-sampling edge
  function automatic void model(input bit cl, input bit wr, output int lat, output int atts,
                                output rggen_status st, output logic [31:0] data);
    int c, d, e;
    bit done;
    c = 1;
    done = 1'b0;
    lat = 0; atts = 0; st = RGGEN_OKAY; data = '0;
    for (int k = 0; k < 3; k++) begin
      if (!done) begin
        d = (scr_k[k] == KSilent) ? 99 : scr_d[k];
        e = cl ? c + ((d > 7) ? 7 : d) : c + scr_s[k] + ((d > 8) ? 8 : d);
        atts = k + 1;
        lat = e + 1;
        if (d <= (cl ? 7 : 8) && scr_k[k] == KRty && k < 2) begin
          c = e + 2;
        end else begin
          done = 1'b1;
          if (d <= (cl ? 7 : 8) && scr_k[k] == KAck) begin
            st = RGGEN_OKAY;
            data = wr ? 32'h0 : scr_rdata;
          end else begin
            st = RGGEN_SLAVE_ERROR;
            data = '0;
          end
        end
      end
    end
  endfunction

  task automatic run_txn(input bit cl, input bit wr, input logic [7:0] a, input logic [31:0] wd,
                         input logic [3:0] sb, input logic [31:0] rd);
    int n, e_lat, e_att, bad, d, exp_len;
    bit got;
    rggen_status e_st, got_st;
    logic [31:0] e_rd, got_rd;
    logic got_cyc;
    @(negedge clk);
    classic = cl;
    acc = wr ? RGGEN_WRITE : RGGEN_READ;
    addr = a; wdata = wd; strb = sb; scr_rdata = rd;
    att = 0; attr_bad = 0;
    for (int k = 0; k < 3; k++) stb_cnt[k] = 0;
    valid = 1'b1;
    n = 0; got = 1'b0; got_st = RGGEN_OKAY; got_rd = '0; got_cyc = 1'b0;
    while (!got && n < 200) begin
      @(negedge clk);
      n++;
      if (rdy) begin
        got = 1'b1; got_st = sts; got_rd = rdat; got_cyc = cyc;
      end
    end
    valid = 1'b0;
    check_eq("ready_seen", 64'(got), 64'd1);
    @(negedge clk);
    check_eq("ready_pulse", 64'(rdy), 64'd0);
    model(cl, wr, e_lat, e_att, e_st, e_rd);
    check_eq("latency", 64'(n), 64'(e_lat));
    check_eq("status", 64'(got_st), 64'(e_st));
    check_eq("read_data", 64'(got_rd), 64'(e_rd));
    check_eq("cyc_at_ready", 64'(got_cyc), 64'd0);
    check_eq("attempts", 64'(att), 64'(e_att));
    check_eq("attrs", 64'(attr_bad), 64'd0);
    bad = 0;
    for (int k = 0; k < e_att && k < 3; k++) begin
      d = (scr_k[k] == KSilent) ? 99 : scr_d[k];
      exp_len = cl ? ((d > 7) ? 7 : d) + 1 : scr_s[k] + 1;
      if (stb_cnt[k] != exp_len) bad++;
    end
    check_eq("stb_len", 64'(bad), 64'd0);
  endtask

  initial begin
    int r, cnt;
    att = 0; attr_bad = 0;
    for (int k = 0; k < 3; k++) begin
      stb_cnt[k] = 0;
      set_att(k, 0, 0, KSilent);
    end
    scr_rdata = '0;

    repeat (3) @(negedge clk);
    check_eq("rst_cyc_stb", {62'd0, cyc, stb}, 64'd0);
    check_eq("rst_we_adr_sel", {51'd0, we, adr, sel}, 64'd0);
    check_eq("rst_dat_w", 64'(dat_w), 64'd0);
    check_eq("rst_ready", 64'(rdy), 64'd0);
    check_eq("rst_status", 64'(sts), 64'(RGGEN_OKAY));
    check_eq("rst_read_data", 64'(rdat), 64'd0);
    i_rst = 1'b0;

    set_att(0, 0, 1, KAck);
    run_txn(1'b0, 1'b1, 8'h10, 32'hA5A5_0001, 4'b0011, 32'h1234_5678);
    set_att(0, 3, 1, KAck);
    run_txn(1'b0, 1'b0, 8'h20, 32'h0, 4'h0, 32'hDEAD_BEEF);
    set_att(0, 0, 1, KRty); set_att(1, 1, 0, KRty); set_att(2, 0, 2, KAck);
    run_txn(1'b0, 1'b0, 8'h30, 32'h0, 4'h0, 32'hCAFE_0003);
    set_att(0, 0, 1, KRty); set_att(1, 0, 1, KRty); set_att(2, 0, 1, KRty);
    run_txn(1'b0, 1'b0, 8'h34, 32'h0, 4'h0, 32'hCAFE_0004);
    set_att(0, 0, 1, KErr);
    run_txn(1'b0, 1'b0, 8'h40, 32'h0, 4'h0, 32'h5555_AAAA);
    set_att(0, 1, 0, KErrAck);
    run_txn(1'b0, 1'b0, 8'h44, 32'h0, 4'h0, 32'h6666_BBBB);
    set_att(0, 0, 0, KSilent);
    run_txn(1'b0, 1'b0, 8'h50, 32'h0, 4'h0, 32'h7777_0000);
    set_att(0, 0, 8, KAck);
    run_txn(1'b0, 1'b0, 8'h54, 32'h0, 4'h0, 32'h8888_0008);
    set_att(0, 0, 9, KAck);
    run_txn(1'b0, 1'b1, 8'h58, 32'h0000_0009, 4'hF, 32'h0);
    set_att(0, 0, 2, KAck);
    run_txn(1'b1, 1'b0, 8'h60, 32'h0, 4'h0, 32'hDEAD_BEEF);
    set_att(0, 0, 0, KSilent);
    run_txn(1'b1, 1'b1, 8'h64, 32'h1111_2222, 4'b0101, 32'h0);
    set_att(0, 0, 7, KAck);
    run_txn(1'b1, 1'b0, 8'h68, 32'h0, 4'h0, 32'h9999_0007);

    // Reset while the cycle is open in WAIT: cyc drops, no response follows
    @(negedge clk);
    classic = 1'b0;
    set_att(0, 0, 0, KSilent);
    acc = RGGEN_READ; addr = 8'h70; att = 0;
    valid = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("cyc_open", 64'(cyc), 64'd1);
    i_rst = 1'b1;
    @(negedge clk);
    check_eq("rst_mid_cyc", {62'd0, cyc, stb}, 64'd0);
    i_rst = 1'b0;
    valid = 1'b0;
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (rdy) cnt++;
    end
    check_eq("rst_mid_no_ready", 64'(cnt), 64'd0);

    for (int i = 0; i < 40; i++) begin
      for (int k = 0; k < 3; k++) begin
        r = $urandom_range(0, 9);
        set_att(k, $urandom_range(0, 3), $urandom_range(0, 9),
                (r < 4) ? KAck : (r == 4) ? KErr : (r < 8) ? KRty : (r == 8) ? KSilent : KErrAck);
      end
      run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
              $urandom, 4'($urandom), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
